pcs_scrambler_gen: RTL and testbench

//  Parametrised self-synchronous x^58+x^39+1 scrambler/descrambler for the 64b/66b PCS.
//  One build-time MODE selects TX scrambling or RX descrambling.

---
 rtl/pcs_pkg.sv | 20 ++
 rtl/pcs_scrambler_gen_if.sv | 26 ++
 rtl/pcs_skid_buf.sv | 68 ++++++
 rtl/pcs_scrambler_gen.sv | 105 ++++++++++
 tb/tb_pcs_scrambler_gen.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_pkg.sv
// Shared constants and helpers for the 64b/66b PCS x^58+x^39+1 scrambler family.
package pcs_pkg;

  localparam int unsigned SCR_HIST_W  = 58;
  localparam int unsigned SCR_TAP_A   = 39;
  localparam int unsigned SCR_TAP_B   = 58;
  localparam int unsigned SCR_MODE_TX = 0;
  localparam int unsigned SCR_MODE_RX = 1;

  typedef enum logic {
    StUnsync,
    StSync
  } scr_state_e;

  // Number of words needed before the whole history comes from line data.
  function automatic int unsigned scr_nsync(input int unsigned width);
    return (SCR_HIST_W + width - 1) / width;
  endfunction

endpackage

// File: rtl/pcs_scrambler_gen_if.sv
// Valid/ready word stream carrying a payload and its sync header.
interface pcs_scrambler_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH  = 2
) ();

  logic [DATA_WIDTH-1:0] data;
  logic [HDR_WIDTH-1:0]  hdr;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output hdr,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  hdr,
    input  valid,
    output ready
  );

endinterface

// File: rtl/pcs_skid_buf.sv
// Output register plus one skid register; in_ready is registered so it has no
// combinational dependence on out_ready.
module pcs_skid_buf #(
  parameter int unsigned WIDTH = 66
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic             accept;

  assign accept = in_valid_i & in_ready_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: the skid word goes first so order is kept.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = in_data_i;
        end
      end
    end else if (accept) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/pcs_scrambler_gen.sv
// Self-synchronous x^58+x^39+1 scrambler (MODE 0) or descrambler (MODE 1) with
// skid-buffered valid/ready, header passthrough, bypass, seed load and sync tracking.
module pcs_scrambler_gen import pcs_pkg::*; #(
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            HDR_WIDTH  = 2,
  parameter int unsigned            MODE       = SCR_MODE_TX,
  parameter logic [SCR_HIST_W-1:0]  SEED       = {SCR_HIST_W{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pcs_scrambler_gen_if.slave    in_if,
  pcs_scrambler_gen_if.master   out_if,
  input  logic                  bypass_i,
  input  logic                  seed_load_i,
  input  logic [SCR_HIST_W-1:0] seed_i,
  output logic                  synced_o
);

  localparam int unsigned TapOff = SCR_TAP_B - SCR_TAP_A;
  localparam int unsigned ExtW   = DATA_WIDTH + SCR_HIST_W;
  localparam int unsigned NSync  = scr_nsync(DATA_WIDTH);
  localparam int unsigned CntW   = $clog2(NSync + 1);
  localparam logic [CntW-1:0] NSyncCnt = CntW'(NSync);
  localparam int unsigned BufW   = DATA_WIDTH + HDR_WIDTH;

  logic [SCR_HIST_W-1:0] hist_q, hist_d;
  logic [ExtW-1:0]       ext;
  logic [DATA_WIDTH-1:0] scr_data;
  logic [CntW-1:0]       cnt_q;
  scr_state_e            state_q;
  logic                  synced_q;
  logic                  accept;
  logic                  advance;
  logic [BufW-1:0]       buf_in;
  logic [BufW-1:0]       buf_out;

  assign accept  = in_if.valid & in_if.ready;
  assign advance = accept & !bypass_i;

  // Bits are produced serially so TX feedback sees outputs of earlier bits in this word.
  always_comb begin
    scr_data = '0;
    ext      = '0;
    ext[SCR_HIST_W-1:0] = hist_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      scr_data[i] = in_if.data[i] ^ ext[i + TapOff] ^ ext[i];
      ext[SCR_HIST_W + i] = (MODE == SCR_MODE_RX) ? in_if.data[i] : scr_data[i];
    end
    hist_d = ext[ExtW-1:DATA_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= SEED;
      cnt_q    <= '0;
      state_q  <= StUnsync;
      synced_q <= 1'b0;
    end else if (seed_load_i) begin
      // A word accepted this cycle has already used the old history.
      hist_q   <= seed_i;
      cnt_q    <= '0;
      state_q  <= StUnsync;
      synced_q <= 1'b0;
    end else if (advance) begin
      hist_q <= hist_d;
      unique case (state_q)
        StUnsync: begin
          cnt_q <= cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == NSyncCnt) begin
            state_q  <= StSync;
            synced_q <= 1'b1;
          end
        end
        StSync: begin
          state_q  <= StSync;
          synced_q <= 1'b1;
        end
        default: begin
          state_q  <= StUnsync;
          synced_q <= 1'b0;
        end
      endcase
    end
  end

  assign synced_o = synced_q | (MODE == SCR_MODE_TX);

  assign buf_in = {in_if.hdr, (bypass_i ? in_if.data : scr_data)};

  pcs_skid_buf #(
    .WIDTH(BufW)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_data_i   (buf_in),
    .in_valid_i  (in_if.valid),
    .in_ready_o  (in_if.ready),
    .out_data_o  (buf_out),
    .out_valid_o (out_if.valid),
    .out_ready_i (out_if.ready)
  );

  assign {out_if.hdr, out_if.data} = buf_out;

endmodule

// File: tb/tb_pcs_scrambler_gen.sv
// Scoreboard bench for pcs_scrambler_gen: TX/RX at 64 bits and a 32-bit loopback.
module tb_pcs_scrambler_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pcs_scrambler_gen_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) a_in ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) a_out ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) b_in ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) b_out ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) c_in ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) lb ();
  pcs_scrambler_gen_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) d_out ();

  logic        a_byp, a_sl, a_synced;
  logic        b_byp, b_sl, b_synced;
  logic        c_byp, c_sl, c_synced;
  logic        d_byp, d_sl, d_synced;
  logic [57:0] a_seed, b_seed, c_seed, d_seed;

  pcs_scrambler_gen #(.DATA_WIDTH(64), .HDR_WIDTH(2), .MODE(0), .SEED(58'h0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_if(a_in), .out_if(a_out),
    .bypass_i(a_byp), .seed_load_i(a_sl), .seed_i(a_seed), .synced_o(a_synced)
  );
  pcs_scrambler_gen #(.DATA_WIDTH(64), .HDR_WIDTH(2), .MODE(1), .SEED(58'h0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_if(b_in), .out_if(b_out),
    .bypass_i(b_byp), .seed_load_i(b_sl), .seed_i(b_seed), .synced_o(b_synced)
  );
  pcs_scrambler_gen #(.DATA_WIDTH(32), .HDR_WIDTH(2), .MODE(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_if(c_in), .out_if(lb),
    .bypass_i(c_byp), .seed_load_i(c_sl), .seed_i(c_seed), .synced_o(c_synced)
  );
  pcs_scrambler_gen #(.DATA_WIDTH(32), .HDR_WIDTH(2), .MODE(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .in_if(lb), .out_if(d_out),
    .bypass_i(d_byp), .seed_load_i(d_sl), .seed_i(d_seed), .synced_o(d_synced)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model history: hist[j] is the line bit j+1 positions back (hist[0] newest).
  function automatic logic [57:0] seed_to_hist(input logic [57:0] s);
    logic [57:0] h;
    for (int j = 0; j < 58; j++) h[j] = s[57-j];
    return h;
  endfunction

  task automatic model_word(input logic [63:0] din, input int w, input bit rx,
                            inout logic [57:0] hist, output logic [63:0] dout);
    logic o;
    dout = '0;
    for (int i = 0; i < w; i++) begin
      o = din[i] ^ hist[38] ^ hist[57];
      dout[i] = o;
      hist = {hist[56:0], (rx ? din[i] : o)};
    end
  endtask

  logic [65:0] sb_a[$];
  logic [57:0] hist_a;
  logic [33:0] lb_q[$];
  int          lb_idx = 0;

  always @(negedge clk) begin
    logic [65:0] e;
    if (rst_n && a_out.valid && a_out.ready) begin
      check_eq("a_sb_nonempty", 128'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check_eq("a_data", a_out.data, e[63:0]);
        check_eq("a_hdr", a_out.hdr, e[65:64]);
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && d_out.valid && d_out.ready) begin
      check_eq("lb_sb_nonempty", 128'(lb_q.size() != 0), 1);
      if (lb_q.size() != 0) begin
        e = lb_q.pop_front();
        lb_idx++;
        check_eq("lb_hdr", d_out.hdr, e[33:32]);
        if (lb_idx == 2) check_eq("lb_synced", d_synced, 1);
        if (lb_idx >= 3) check_eq("lb_data", d_out.data, e[31:0]);
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send_a(input logic [63:0] d, input logic [1:0] h, input logic byp,
                        input logic sl);
    bit          ok;
    logic [63:0] e;
    a_in.data  = d;
    a_in.hdr   = h;
    a_in.valid = 1'b1;
    a_byp      = byp;
    a_sl       = sl;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_in.ready) begin
        ok = 1;
        break;
      end
    end
    check_eq("a_accept", 128'(ok), 1);
    if (ok) begin
      if (byp) e = d;
      else model_word(d, 64, 0, hist_a, e);
      sb_a.push_back({h, e});
      if (sl) hist_a = seed_to_hist(a_seed);
    end
    @(posedge clk); #1;
    a_in.valid = 1'b0;
    a_byp      = 1'b0;
    a_sl       = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    for (int n = 0; n < 20 && sb_a.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, sb_a.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] e64;
    int          acc;
    int          cyc;
    bit          took;

    a_in.data = '0; a_in.hdr = '0; a_in.valid = 1'b0; a_out.ready = 1'b1;
    b_in.data = '0; b_in.hdr = '0; b_in.valid = 1'b0; b_out.ready = 1'b1;
    c_in.data = '0; c_in.hdr = '0; c_in.valid = 1'b0; d_out.ready = 1'b1;
    a_byp = 0; a_sl = 0; a_seed = '0;
    b_byp = 0; b_sl = 0; b_seed = '0;
    c_byp = 0; c_sl = 0; c_seed = '0;
    d_byp = 0; d_sl = 0; d_seed = '0;

    // Reset values, with a word offered during reset that must be ignored.
    a_in.valid = 1'b1;
    a_in.data  = 64'hdead_beef_0000_0001;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", a_in.ready, 0);
    check_eq("rst_out_valid", a_out.valid, 0);
    check_eq("rst_out_data", a_out.data, 0);
    check_eq("rst_out_hdr", a_out.hdr, 0);
    check_eq("rst_synced_tx", a_synced, 1);
    check_eq("rst_synced_rx", b_synced, 0);
    a_in.valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_in_ready", a_in.ready, 1);
    check_eq("rel_out_valid", a_out.valid, 0);
    hist_a = seed_to_hist(58'h0);

    // Known TX vector with one-cycle latency.
    send_a(64'h1, 2'b01, 0, 0);
    check_eq("t1_valid", a_out.valid, 1);
    check_eq("t1_data", a_out.data, 64'h0400_0080_0000_0001);
    check_eq("t1_hdr", a_out.hdr, 2'b01);

    // Known RX vector; NSYNC is 1 at 64 bits.
    b_in.data  = 64'h0400_0080_0000_0001;
    b_in.hdr   = 2'b10;
    b_in.valid = 1'b1;
    @(negedge clk);
    check_eq("t2_ready", b_in.ready, 1);
    check_eq("t2_pre_sync", b_synced, 0);
    @(posedge clk); #1;
    b_in.valid = 1'b0;
    check_eq("t2_valid", b_out.valid, 1);
    check_eq("t2_data", b_out.data, 64'h1);
    check_eq("t2_hdr", b_out.hdr, 2'b10);
    check_eq("t2_synced", b_synced, 1);

    // Bypass on the third word of a stream; the model skips it in its history.
    for (int k = 0; k < 6; k++) begin
      send_a({$urandom, $urandom}, 2'($urandom_range(1, 2)), (k == 2), 0);
    end
    drain_a("t5_drain");

    // Output stalled for five cycles while input keeps offering words.
    a_out.ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      a_in.valid = 1'b1;
      a_in.data  = {$urandom, $urandom} ^ 64'(acc);
      a_in.hdr   = 2'b10;
      @(negedge clk);
      if (c == 2) check_eq("t4_rdy_low", a_in.ready, 0);
      if (a_in.ready) begin
        model_word(a_in.data, 64, 0, hist_a, e64);
        sb_a.push_back({a_in.hdr, e64});
        acc++;
      end
      @(posedge clk); #1;
    end
    a_in.valid = 1'b0;
    check_eq("t4_stored", acc, 2);
    check_eq("t4_hold_valid", a_out.valid, 1);
    if (sb_a.size() != 0) check_eq("t4_hold_data", a_out.data, sb_a[0][63:0]);
    a_out.ready = 1'b1;
    drain_a("t4_drain");
    check_eq("t4_idle", a_out.valid, 0);

    // TX->RX loopback at 32 bits with a random RX seed and random backpressure.
    @(posedge clk); #1;
    d_seed = 58'({$urandom, $urandom});
    d_sl   = 1'b1;
    @(posedge clk); #1;
    d_sl = 1'b0;
    check_eq("lb_unsync", d_synced, 0);
    check_eq("lb_tx_synced", c_synced, 1);
    acc = 0;
    cyc = 0;
    c_in.data = $urandom;
    c_in.hdr  = 2'($urandom_range(1, 2));
    while (acc < 1000 && cyc < 20000) begin
      c_in.valid  = ($urandom_range(0, 3) != 0);
      d_out.ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = c_in.valid && c_in.ready;
      if (took) begin
        lb_q.push_back({c_in.hdr, c_in.data});
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        c_in.data = $urandom;
        c_in.hdr  = 2'($urandom_range(1, 2));
      end
      cyc++;
    end
    c_in.valid  = 1'b0;
    d_out.ready = 1'b1;
    check_eq("lb_count", acc, 1000);
    for (int n = 0; n < 50 && lb_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check_eq("lb_drain", lb_q.size(), 0);
    check_eq("lb_outputs", lb_idx, 1000);

    // Seed load coincident with an accept, then more words under the new seed.
    a_seed = 58'({$urandom, $urandom});
    send_a({$urandom, $urandom}, 2'b01, 0, 1);
    for (int k = 0; k < 3; k++) send_a({$urandom, $urandom}, 2'b10, 0, 0);
    drain_a("t6_drain");

    // Fill both storage registers, then reset mid-stream.
    a_out.ready = 1'b0;
    send_a({$urandom, $urandom}, 2'b01, 0, 0);
    send_a({$urandom, $urandom}, 2'b01, 0, 0);
    check_eq("t6_full", a_in.ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", a_out.valid, 0);
    check_eq("t6_rst_ready", a_in.ready, 0);
    check_eq("t6_rst_synced", b_synced, 0);
    sb_a.delete();
    hist_a = seed_to_hist(58'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out.ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rel_ready", a_in.ready, 1);
    check_eq("t6_rel_synced", b_synced, 0);
    send_a(64'h1, 2'b01, 0, 0);
    check_eq("t6_seed_data", a_out.data, 64'h0400_0080_0000_0001);
    drain_a("t6_final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
